status_reg: RTL and testbench

- 6502 processor status register (P); sits directly downstream of the ALU.
- Captures the ALU's FLAG_OUT under a per-bit write mask and executes the flag instructions SEC/CLC/SEI/CLI/SED/CLD/CLV.
- Handles PLP/RTI loads and builds the pushed status byte for PHP/BRK/IRQ/NMI.
- Feeds P back to the ALU's FLAG_IN, and provides instruction-boundary IRQ masking and NMI edge detection to the sequencer.

---
 rtl/status_reg.sv | 111 +++++++++++
 tb/tb_status_reg.sv | 138 +++++++++++++
 2 files changed

// File: rtl/status_reg.sv
// 6502 processor status register: ALU flag capture, flag instructions, PLP/RTI load,
// push byte, boundary-latched IRQ mask and NMI edge detect. STATUS_CMOS_DCLR_EN: INT_ACK also clears D.
module status_reg #(
  parameter logic [7:0] RESET_P  = 8'h24,
  parameter int         NMI_SYNC = 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] ALU_FLAG,
  input  logic [7:0] ALU_MASK,
  input  logic [3:0] FLAG_CTRL,
  input  logic [7:0] DATA_IN,
  input  logic       PUSH_BRK,
  input  logic       INT_ACK,
  input  logic       SYNC,
  input  logic       IRQ_N,
  input  logic       NMI_N,
  input  logic       NMI_ACK,
  output logic [7:0] FLAG,
  output logic [7:0] PUSH_DATA,
  output logic       IRQ_PENDING,
  output logic       NMI_PENDING
);

  localparam int B_C = 0, B_Z = 1, B_I = 2, B_D = 3, B_B = 4, B_5 = 5, B_V = 6;

  typedef enum logic [3:0] {
    CT_NOP = 4'd0, CT_SEC = 4'd1, CT_CLC = 4'd2, CT_SEI = 4'd3, CT_CLI = 4'd4,
    CT_SED = 4'd5, CT_CLD = 4'd6, CT_CLV = 4'd7, CT_PULL = 4'd8
  } flag_ctrl_e;

  localparam logic [7:0] RST_VAL = (RESET_P | 8'h20) & 8'hEF;

  logic [7:0]          p_q, p_d;
  logic                imask_q;
  logic [NMI_SYNC-1:0] irq_sync_q, nmi_sync_q;
  logic                nmi_prev_q;
  logic                irq_s, nmi_s, nmi_edge;

  // Flag next-state: ALU merge, then flag op, then INT_ACK, with PULL overriding everything.
  always_comb begin
    p_d = (p_q & ~ALU_MASK) | (ALU_FLAG & ALU_MASK);
    case (flag_ctrl_e'(FLAG_CTRL))
      CT_SEC:  p_d[B_C] = 1'b1;
      CT_CLC:  p_d[B_C] = 1'b0;
      CT_SEI:  p_d[B_I] = 1'b1;
      CT_CLI:  p_d[B_I] = 1'b0;
      CT_SED:  p_d[B_D] = 1'b1;
      CT_CLD:  p_d[B_D] = 1'b0;
      CT_CLV:  p_d[B_V] = 1'b0;
      default: ;
    endcase
    if (INT_ACK) begin
      p_d[B_I] = 1'b1;
`ifdef STATUS_CMOS_DCLR_EN
      p_d[B_D] = 1'b0;
`else
      p_d[B_D] = p_d[B_D];
`endif
    end
    if (FLAG_CTRL == CT_PULL) p_d = DATA_IN;
    p_d[B_5] = 1'b1;
    p_d[B_B] = 1'b0;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) p_q <= RST_VAL;
    else     p_q <= p_d;
  end

  assign FLAG      = p_q;
  assign PUSH_DATA = {p_q[7:6], 1'b1, PUSH_BRK, p_q[3:0]};

  // Synchronizer chains, idle-high so reset never looks like an edge.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      irq_sync_q <= '1;
      nmi_sync_q <= '1;
    end else begin
      irq_sync_q[0] <= IRQ_N;
      nmi_sync_q[0] <= NMI_N;
      for (int i = 1; i < NMI_SYNC; i++) begin
        irq_sync_q[i] <= irq_sync_q[i-1];
        nmi_sync_q[i] <= nmi_sync_q[i-1];
      end
    end
  end

  assign irq_s    = irq_sync_q[NMI_SYNC-1];
  assign nmi_s    = nmi_sync_q[NMI_SYNC-1];
  assign nmi_edge = nmi_prev_q & ~nmi_s;

  // IMASK samples I only at instruction boundaries, giving the 6502's one-instruction IRQ lag.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      imask_q     <= 1'b1;
      IRQ_PENDING <= 1'b0;
      nmi_prev_q  <= 1'b1;
      NMI_PENDING <= 1'b0;
    end else begin
      if (SYNC) imask_q <= p_q[B_I];
      IRQ_PENDING <= ~irq_s & ~imask_q;
      nmi_prev_q  <= nmi_s;
      NMI_PENDING <= nmi_edge | (NMI_PENDING & ~NMI_ACK);
    end
  end

  initial begin : p_param_chk
  end

endmodule

// File: tb/tb_status_reg.sv
// Directed self-checking bench for status_reg with default parameters.
module tb_status_reg;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] ALU_FLAG, ALU_MASK, DATA_IN;
  logic [3:0] FLAG_CTRL;
  logic       PUSH_BRK, INT_ACK, SYNC, IRQ_N, NMI_N, NMI_ACK;
  logic [7:0] FLAG, PUSH_DATA;
  logic       IRQ_PENDING, NMI_PENDING;

  int checks = 0;
  int errors = 0;

  status_reg dut (
    .CLK(CLK), .RST(RST), .ALU_FLAG(ALU_FLAG), .ALU_MASK(ALU_MASK),
    .FLAG_CTRL(FLAG_CTRL), .DATA_IN(DATA_IN), .PUSH_BRK(PUSH_BRK),
    .INT_ACK(INT_ACK), .SYNC(SYNC), .IRQ_N(IRQ_N), .NMI_N(NMI_N),
    .NMI_ACK(NMI_ACK), .FLAG(FLAG), .PUSH_DATA(PUSH_DATA),
    .IRQ_PENDING(IRQ_PENDING), .NMI_PENDING(NMI_PENDING)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Advance one rising edge; inputs change and outputs are sampled 1ns later.
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  initial begin
    RST = 1'b1; ALU_FLAG = 8'h00; ALU_MASK = 8'h00; DATA_IN = 8'h00;
    FLAG_CTRL = 4'd0; PUSH_BRK = 1'b1; INT_ACK = 1'b0; SYNC = 1'b0;
    IRQ_N = 1'b1; NMI_N = 1'b1; NMI_ACK = 1'b0;
    step(3);
    chk("rst_flag", FLAG, 8'h24);
    chk("rst_push", PUSH_DATA, 8'h34);
    chk("rst_irq", {7'd0, IRQ_PENDING}, 8'h00);
    chk("rst_nmi", {7'd0, NMI_PENDING}, 8'h00);
    RST = 1'b0;
    step();
    chk("idle_hold", FLAG, 8'h24);

    // ALU merge under mask
    ALU_FLAG = 8'hC3; ALU_MASK = 8'h83;
    step();
    chk("alu_mask", FLAG, 8'hA7);
    ALU_MASK = 8'h00;

    // Flag ops and their priority over the ALU
    FLAG_CTRL = 4'd2; step(); chk("clc", FLAG, 8'hA6);
    FLAG_CTRL = 4'd1; ALU_FLAG = 8'h00; ALU_MASK = 8'h01;
    step(); chk("sec_over_alu", FLAG, 8'hA7);
    ALU_MASK = 8'h00;
    FLAG_CTRL = 4'd8; DATA_IN = 8'hFF; INT_ACK = 1'b1;
    step(); chk("pull_over_ack", FLAG, 8'hEF);
    INT_ACK = 1'b0;
    PUSH_BRK = 1'b0; #1 chk("push_irq", PUSH_DATA, 8'hEF);
    PUSH_BRK = 1'b1; #1 chk("push_brk", PUSH_DATA, 8'hFF);
    FLAG_CTRL = 4'd9; DATA_IN = 8'h00;
    step(); chk("reserved_nop", FLAG, 8'hEF);
    FLAG_CTRL = 4'd7; step(); chk("clv", FLAG, 8'hAF);
    FLAG_CTRL = 4'd6; step(); chk("cld", FLAG, 8'hA7);
    FLAG_CTRL = 4'd5; step(); chk("sed", FLAG, 8'hAF);
    FLAG_CTRL = 4'd8; DATA_IN = 8'h10;
    step(); chk("pull_b5_ignored", FLAG, 8'h20);

    // IRQ masking lags by one boundary
    FLAG_CTRL = 4'd3; step(); chk("sei", FLAG, 8'h24);
    FLAG_CTRL = 4'd0; IRQ_N = 1'b0;
    step(4); chk("irq_masked", {7'd0, IRQ_PENDING}, 8'h00);
    FLAG_CTRL = 4'd4; step(); FLAG_CTRL = 4'd0;
    chk("cli", FLAG, 8'h20);
    chk("irq_before_sync", {7'd0, IRQ_PENDING}, 8'h00);
    SYNC = 1'b1; step(); SYNC = 1'b0;
    chk("irq_at_sync", {7'd0, IRQ_PENDING}, 8'h00);
    step(); chk("irq_after_sync", {7'd0, IRQ_PENDING}, 8'h01);
    FLAG_CTRL = 4'd3; step(); FLAG_CTRL = 4'd0;
    chk("irq_after_sei", {7'd0, IRQ_PENDING}, 8'h01);
    SYNC = 1'b1; step(); SYNC = 1'b0;
    chk("irq_sei_sync", {7'd0, IRQ_PENDING}, 8'h01);
    step(); chk("irq_masked_again", {7'd0, IRQ_PENDING}, 8'h00);
    IRQ_N = 1'b1;

    // NMI edge detection
    NMI_N = 1'b0;
    step(2); chk("nmi_early", {7'd0, NMI_PENDING}, 8'h00);
    step(); chk("nmi_edge", {7'd0, NMI_PENDING}, 8'h01);
    NMI_ACK = 1'b1; step(); NMI_ACK = 1'b0;
    chk("nmi_ack", {7'd0, NMI_PENDING}, 8'h00);
    step(5); chk("nmi_held_low", {7'd0, NMI_PENDING}, 8'h00);
    NMI_N = 1'b1; step(3); NMI_N = 1'b0;
    step(3); chk("nmi_reedge", {7'd0, NMI_PENDING}, 8'h01);
    NMI_N = 1'b1; step(3); chk("nmi_stays", {7'd0, NMI_PENDING}, 8'h01);
    NMI_N = 1'b0; step(2);
    NMI_ACK = 1'b1; step(); NMI_ACK = 1'b0;
    chk("nmi_edge_beats_ack", {7'd0, NMI_PENDING}, 8'h01);
    NMI_ACK = 1'b1; step(); NMI_ACK = 1'b0;
    chk("nmi_ack2", {7'd0, NMI_PENDING}, 8'h00);

    // INT_ACK and D
    FLAG_CTRL = 4'd8; DATA_IN = 8'h2C; step(); FLAG_CTRL = 4'd0;
    chk("pull_2c", FLAG, 8'h2C);
    INT_ACK = 1'b1; step(); INT_ACK = 1'b0;
`ifdef STATUS_CMOS_DCLR_EN
    chk("int_ack_d", FLAG, 8'h24);
`else
    chk("int_ack_d", FLAG, 8'h2C);
`endif

    // Asynchronous reset mid-update
    FLAG_CTRL = 4'd8; DATA_IN = 8'hFF; step();
    chk("pull_ff", FLAG, 8'hEF);
    NMI_N = 1'b1; step(3); NMI_N = 1'b0; step(3);
    chk("nmi_pre_rst", {7'd0, NMI_PENDING}, 8'h01);
    DATA_IN = 8'hC3;
    #1 RST = 1'b1;
    #1 chk("rst_async_flag", FLAG, 8'h24);
    chk("rst_async_nmi", {7'd0, NMI_PENDING}, 8'h00);
    step(); chk("rst_hold_flag", FLAG, 8'h24);
    RST = 1'b0; FLAG_CTRL = 4'd0;
    step(); chk("post_rst", FLAG, 8'h24);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
